// File: rtl/mem_access_unit.sv
// Load/store front end: one request in, one checked data-memory access, one response out.
// Optional alignment trap is compiled in with `define LSU_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 100,
  parameter int TAG_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [TAG_W-1:0]  resp_tag,
  output logic              resp_fault,
  output logic [1:0]        resp_fault_code,
  output logic [2:0]        dm_funct3,
  output logic [ADDR_W-1:0] dm_address,
  output logic              dm_memwrite,
  output logic              dm_memread,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

  // One extra address bit keeps a wrapping end address from looking in range.
  function automatic logic [1:0] fault_code_f(input logic              we,
                                              input logic [2:0]        f3,
                                              input logic [ADDR_W-1:0] addr);
    logic            legal_s;
    logic            mis_s;
    logic [ADDR_W:0] size_m1_s;
    logic [ADDR_W:0] last_s;
    logic [1:0]      code_s;
    case (f3)
      3'b000, 3'b001, 3'b010: legal_s = 1'b1;
      3'b100, 3'b101:         legal_s = ~we;
      default:                legal_s = 1'b0;
    endcase
    case (f3[1:0])
      2'b00:   size_m1_s = {(ADDR_W+1){1'b0}};
      2'b01:   size_m1_s = {{ADDR_W{1'b0}}, 1'b1};
      default: size_m1_s = {{(ADDR_W-1){1'b0}}, 2'b11};
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    case (f3[1:0])
      2'b01:   mis_s = addr[0];
      2'b10:   mis_s = (addr[1:0] != 2'b00);
      default: mis_s = 1'b0;
    endcase
`else
    mis_s = 1'b0;
`endif
    last_s = {1'b0, addr} + size_m1_s;
    if (!legal_s) begin
      code_s = 2'b11;
    end else if (mis_s) begin
      code_s = 2'b01;
    end else if (last_s > LAST_BYTE) begin
      code_s = 2'b10;
    end else begin
      code_s = 2'b00;
    end
    return code_s;
  endfunction

  state_t            state_r;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [TAG_W-1:0]  tag_r;
  logic [1:0]        fault_r;
  logic              resp_valid_r;
  logic [DATA_W-1:0] resp_rdata_r;
  logic [TAG_W-1:0]  resp_tag_r;
  logic              resp_fault_r;
  logic [1:0]        resp_fault_code_r;
  logic              memwrite_s;
  logic              memread_s;

  // Request/response FSM with latched request fields and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= IDLE;
      we_r              <= 1'b0;
      funct3_r          <= 3'b000;
      addr_r            <= {ADDR_W{1'b0}};
      wdata_r           <= {DATA_W{1'b0}};
      tag_r             <= {TAG_W{1'b0}};
      fault_r           <= 2'b00;
      resp_valid_r      <= 1'b0;
      resp_rdata_r      <= {DATA_W{1'b0}};
      resp_tag_r        <= {TAG_W{1'b0}};
      resp_fault_r      <= 1'b0;
      resp_fault_code_r <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            tag_r    <= req_tag;
            fault_r  <= fault_code_f(req_we, req_funct3, req_addr);
            state_r  <= ACCESS;
          end else begin
            state_r  <= IDLE;
          end
        end
        ACCESS: begin
          resp_valid_r      <= 1'b1;
          resp_tag_r        <= tag_r;
          resp_fault_r      <= (fault_r != 2'b00);
          resp_fault_code_r <= fault_r;
          resp_rdata_r      <= (!we_r && fault_r == 2'b00) ? dm_rdata : {DATA_W{1'b0}};
          state_r           <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r      <= RESP;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Strobes follow the state directly so an asynchronous reset drops them at once.
  always_comb begin
    memwrite_s = 1'b0;
    memread_s  = 1'b0;
    if (state_r == ACCESS && fault_r == 2'b00) begin
      memwrite_s = we_r;
      memread_s  = ~we_r;
    end else begin
      memwrite_s = 1'b0;
      memread_s  = 1'b0;
    end
  end

  assign req_ready       = (state_r == IDLE);
  assign resp_valid      = resp_valid_r;
  assign resp_rdata      = resp_rdata_r;
  assign resp_tag        = resp_tag_r;
  assign resp_fault      = resp_fault_r;
  assign resp_fault_code = resp_fault_code_r;
  assign dm_funct3       = funct3_r;
  assign dm_address      = addr_r;
  assign dm_wdata        = wdata_r;
  assign dm_memwrite     = memwrite_s;
  assign dm_memread      = memread_s;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a 100-byte behavioural data memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_tag;
  logic        resp_fault;
  logic [1:0]  resp_fault_code;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_address, dm_wdata, dm_rdata;
  logic        dm_memwrite, dm_memread;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  tag;
    logic [1:0]  code;
    logic [3:0]  rd;
    logic [3:0]  wr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_cnt = 0, wr_cnt = 0, rd_seen = 0, wr_seen = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_fault(resp_fault), .resp_fault_code(resp_fault_code),
    .dm_funct3(dm_funct3), .dm_address(dm_address), .dm_memwrite(dm_memwrite),
    .dm_memread(dm_memread), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: little-endian, extends loads per funct3.
  logic [7:0] mem [0:99] = '{default: 8'h00};
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    b0 = (dm_address        < 32'd100) ? mem[dm_address]          : 8'h00;
    b1 = (dm_address + 32'd1 < 32'd100) ? mem[dm_address + 32'd1] : 8'h00;
    b2 = (dm_address + 32'd2 < 32'd100) ? mem[dm_address + 32'd2] : 8'h00;
    b3 = (dm_address + 32'd3 < 32'd100) ? mem[dm_address + 32'd3] : 8'h00;
    case (dm_funct3)
      3'b000:  dm_rdata = {{24{b0[7]}}, b0};
      3'b001:  dm_rdata = {{16{b1[7]}}, b1, b0};
      3'b100:  dm_rdata = {24'h000000, b0};
      3'b101:  dm_rdata = {16'h0000, b1, b0};
      default: dm_rdata = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (dm_memwrite) begin
      for (int k = 0; k < 4; k++) begin
        if ((k == 0 || (k == 1 && dm_funct3[1:0] != 2'b00) || dm_funct3[1:0] == 2'b10) &&
            dm_address + k < 32'd100)
          mem[dm_address + k] <= dm_wdata[8*k +: 8];
      end
    end
  end

  always @(posedge clk) begin
    if (dm_memread)  rd_cnt <= rd_cnt + 1;
    if (dm_memwrite) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got tag %h expected no response", resp_tag);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_tag", {27'd0, resp_tag}, {27'd0, e.tag});
        check("resp_fault", {31'd0, resp_fault}, {31'd0, (e.code != 2'b00)});
        check("resp_code", {30'd0, resp_fault_code}, {30'd0, e.code});
        check("read_strobes", rd_cnt - rd_seen, {28'd0, e.rd});
        check("write_strobes", wr_cnt - wr_seen, {28'd0, e.wr});
        rd_seen = rd_cnt;
        wr_seen = wr_cnt;
      end
    end
  end

  // Issue one request; inputs change 1 time unit after the rising edge.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] tag,
                        input logic [31:0] e_rdata, input logic [1:0] e_code,
                        input bit stall);
    int   lat;
    exp_t x;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    x.rdata = e_rdata;
    x.tag   = tag;
    x.code  = e_code;
    x.rd    = (!we && e_code == 2'b00) ? 4'd1 : 4'd0;
    x.wr    = ( we && e_code == 2'b00) ? 4'd1 : 4'd0;
    exp_q.push_back(x);
    resp_ready = ~stall;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_tag = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 32'd2);
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        check("stall_valid", {31'd0, resp_valid}, 32'd1);
        check("stall_ready", {31'd0, req_ready}, 32'd0);
        check("stall_rdata", resp_rdata, e_rdata);
        check("stall_tag", {27'd0, resp_tag}, {27'd0, tag});
        if (i == 0) begin
          req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
          req_addr = 32'h08; req_wdata = 32'h0; req_tag = 5'd30;
        end
        @(posedge clk); #1;
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; resp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; req_tag = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rdata", resp_rdata, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a store access
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h12345678; req_tag = 5'd21;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("access_memwrite", {31'd0, dm_memwrite}, 32'd1);
    check("access_addr", dm_address, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("rst_memwrite", {31'd0, dm_memwrite}, 32'd0);
    check("rst_memread", {31'd0, dm_memread}, 32'd0);
    check("rst_dm_addr", dm_address, 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_tag", {27'd0, resp_tag}, 32'd0);
    check("rst_fault", {29'd0, resp_fault, resp_fault_code}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mem_untouched", {mem[19], mem[18], mem[17], mem[16]}, 32'd0);
    check("rst_no_write", wr_cnt, 32'd0);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Store then reload, sign/zero extension
    do_req(1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 5'd3, 32'h0, 2'b00, 1'b0);
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 5'd7, 32'hDEADBEEF, 2'b00, 1'b0);
    do_req(1'b0, 3'b000, 32'h08, 32'h0, 5'd1, 32'hFFFFFFEF, 2'b00, 1'b0);
    do_req(1'b0, 3'b100, 32'h08, 32'h0, 5'd2, 32'h000000EF, 2'b00, 1'b0);
    do_req(1'b0, 3'b101, 32'h0A, 32'h0, 5'd4, 32'h0000DEAD, 2'b00, 1'b0);

    // Range boundaries and wrap-around
    do_req(1'b0, 3'b010, 32'h62, 32'h0, 5'd5, 32'h0, TRAP ? 2'b01 : 2'b10, 1'b0);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd6, 32'h0, TRAP ? 2'b01 : 2'b10, 1'b0);
    do_req(1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 5'd8, 32'h0, 2'b10, 1'b0);
    do_req(1'b1, 3'b010, 32'h64, 32'h55555555, 5'd10, 32'h0, 2'b10, 1'b0);
    do_req(1'b1, 3'b010, 32'h60, 32'hCAFEF00D, 5'd12, 32'h0, 2'b00, 1'b0);
    do_req(1'b0, 3'b010, 32'h60, 32'h0, 5'd11, 32'hCAFEF00D, 2'b00, 1'b0);
    do_req(1'b0, 3'b000, 32'h63, 32'h0, 5'd19, 32'hFFFFFFCA, 2'b00, 1'b0);
    do_req(1'b0, 3'b001, 32'h63, 32'h0, 5'd20, 32'h0, TRAP ? 2'b01 : 2'b10, 1'b0);

    // Misaligned halfword
    do_req(1'b1, 3'b000, 32'h03, 32'h000000C4, 5'd13, 32'h0, 2'b00, 1'b0);
    do_req(1'b1, 3'b010, 32'h04, 32'h11223380, 5'd14, 32'h0, 2'b00, 1'b0);
    do_req(1'b0, 3'b001, 32'h03, 32'h0, 5'd15, TRAP ? 32'h0 : 32'hFFFF80C4,
           TRAP ? 2'b01 : 2'b00, 1'b0);

    // Illegal funct3 (highest priority)
    do_req(1'b1, 3'b011, 32'h08, 32'h0, 5'd16, 32'h0, 2'b11, 1'b0);
    do_req(1'b0, 3'b110, 32'h00, 32'h0, 5'd17, 32'h0, 2'b11, 1'b0);
    do_req(1'b0, 3'b011, 32'hFFFFFFFF, 32'h0, 5'd22, 32'h0, 2'b11, 1'b0);
    do_req(1'b1, 3'b100, 32'h08, 32'h0, 5'd23, 32'h0, 2'b11, 1'b0);
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 5'd24, 32'hDEADBEEF, 2'b00, 1'b0);

    // Back-pressure with an ignored request during the stall
    do_req(1'b0, 3'b010, 32'h04, 32'h0, 5'd18, 32'h11223380, 2'b00, 1'b1);
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 5'd25, 32'hDEADBEEF, 2'b00, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("final_resp_valid", {31'd0, resp_valid}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
